// File: rtl/alu_seq_unit.sv
// ALU control and execution unit: decodes aluop/funct, runs single-cycle ops directly
// and shifts/multiply iteratively, returning a registered result with start/busy/done.
module alu_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         aluop,
    input  logic [3:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_SLT = 4'd4,
        OP_SLL = 4'd5, OP_SRL = 4'd6, OP_MUL = 4'd7, OP_NOR = 4'd8, OP_ILL = 4'd9
    } op_t;

    localparam logic [SHAMT_W:0] CNT_ONE  = {{SHAMT_W{1'b0}}, 1'b1};
    localparam logic [SHAMT_W:0] CNT_FULL = (SHAMT_W + 1)'(WIDTH);

    function automatic op_t decode_op(input logic [1:0] op_sel, input logic [3:0] fn);
        op_t op;
        case (op_sel)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_NOR;
            2'b10: begin
                case (fn)
                    4'b0000: op = OP_ADD;
                    4'b0010: op = OP_SUB;
                    4'b0100: op = OP_AND;
                    4'b0101: op = OP_OR;
                    4'b1010: op = OP_SLT;
                    4'b0011: op = OP_SLL;
                    4'b0111: op = OP_SRL;
                    4'b1000: op = OP_MUL;
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    // Shifts reaching this function have a zero shift amount, so they pass b through.
    function automatic logic [WIDTH-1:0] single_result(input op_t op,
                                                       input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:         r = x + y;
            OP_SUB:         r = x - y;
            OP_AND:         r = x & y;
            OP_OR:          r = x | y;
            OP_NOR:         r = ~(x | y);
            OP_SLT:         r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLL, OP_SRL: r = y;
            default:        r = '0;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic               done_q, done_d;
    logic               wr_en_s;
    logic [WIDTH-1:0]   wr_val_s;
    logic               wr_ill_s;

    // Next-state, datapath step and result write-back selection
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        wr_en_s   = 1'b0;
        wr_val_s  = '0;
        wr_ill_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = decode_op(aluop, funct);
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
                    if (((op_d == OP_SLL) || (op_d == OP_SRL)) && (shamt != '0)) begin
                        cnt_d   = {1'b0, shamt};
                        state_d = S_RUN;
                    end else if (op_d == OP_MUL) begin
                        cnt_d   = CNT_FULL;
                        state_d = S_RUN;
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_val_s = single_result(op_d, a, b);
                        wr_ill_s = (op_d == OP_ILL);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                case (op_q)
                    OP_SLL: begin
                        b_d      = {b_q[WIDTH-2:0], 1'b0};
                        wr_val_s = b_d;
                    end
                    OP_SRL: begin
                        b_d      = {1'b0, b_q[WIDTH-1:1]};
                        wr_val_s = b_d;
                    end
                    OP_MUL: begin
                        acc_d    = b_q[0] ? (acc_q + a_q) : acc_q;
                        a_d      = {a_q[WIDTH-2:0], 1'b0};
                        b_d      = {1'b0, b_q[WIDTH-1:1]};
                        wr_val_s = acc_d;
                    end
                    default: begin
                        wr_val_s = '0;
                    end
                endcase
                if (cnt_q == CNT_ONE) begin
                    wr_en_s = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_en_s) begin
            result_d  = wr_val_s;
            zero_d    = (wr_val_s == '0);
            illegal_d = wr_ill_s;
            done_d    = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: a latency/result model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_seq_unit;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    aluop;
    logic [3:0]    funct;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          zero;
    logic          illegal;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    alu_seq_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what a request produces and how many cycles until done.
    function automatic void ref_op(input logic [1:0] op, input logic [3:0] fn,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [SW-1:0] sh,
                                   output logic [W-1:0] res, output logic ill, output int lat);
        res = '0; ill = 1'b0; lat = 1;
        if (op == 2'b00)      res = x + y;
        else if (op == 2'b01) res = x - y;
        else if (op == 2'b11) res = ~(x | y);
        else begin
            case (fn)
                4'b0000: res = x + y;
                4'b0010: res = x - y;
                4'b0100: res = x & y;
                4'b0101: res = x | y;
                4'b1010: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                4'b0011: begin res = y << sh; lat = 1 + int'(sh); end
                4'b0111: begin res = y >> sh; lat = 1 + int'(sh); end
                4'b1000: begin res = x * y;   lat = 1 + W; end
                default: ill = 1'b1;
            endcase
        end
    endfunction

    logic [W-1:0] m_res_s;
    logic         m_ill_s;
    int           m_lat_s;
    always_comb ref_op(aluop, funct, a, b, shamt, m_res_s, m_ill_s, m_lat_s);

    logic         m_busy, m_done, m_zero, m_ill;
    logic [W-1:0] m_result, m_pend;
    int           m_rem;

    // Reference state: outstanding request countdown and visible outputs
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0; m_zero <= 1'b1;
            m_ill <= 1'b0; m_rem <= 0;
        end else if (m_busy) begin
            if (m_rem == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend;
                m_zero <= (m_pend == '0); m_ill <= 1'b0; m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1; m_done <= 1'b0;
            end
        end else if (start) begin
            if (m_lat_s == 1) begin
                m_done <= 1'b1; m_result <= m_res_s; m_zero <= (m_res_s == '0);
                m_ill <= m_ill_s;
            end else begin
                m_busy <= 1'b1; m_rem <= m_lat_s - 1; m_pend <= m_res_s; m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy",    busy,    m_busy);
            cmp("done",    done,    m_done);
            cmp("result",  result,  m_result);
            cmp("zero",    zero,    m_zero);
            cmp("illegal", illegal, m_ill);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] fn, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [SW-1:0] sh);
        aluop = op; funct = fn; a = x; b = y; shamt = sh; start = 1'b1;
    endtask

    int dcount;

    initial begin
        reset = 1'b1; start = 1'b0; aluop = 2'b00; funct = 4'b0000;
        a = '0; b = '0; shamt = '0;
        tick(2);
        reset = 1'b0;
        chk_en = 1'b1;
        cmp("rst_result", result, 32'h0);
        cmp("rst_zero", zero, 32'h1);
        cmp("rst_busy", busy, 32'h0);
        cmp("rst_done", done, 32'h0);
        cmp("rst_illegal", illegal, 32'h0);

        issue(2'b10, 4'b0000, 32'd5, 32'd7, 5'd0);
        tick(1);
        start = 1'b0;
        cmp("add_done", done, 32'h1);
        cmp("add_result", result, 32'd12);
        cmp("add_zero", zero, 32'h0);
        cmp("add_busy", busy, 32'h0);

        issue(2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1, 5'd0);
        tick(1);
        cmp("slt_result", result, 32'd1);
        issue(2'b01, 4'b0000, 32'd9, 32'd9, 5'd0);
        tick(1);
        start = 1'b0;
        cmp("sub_done", done, 32'h1);
        cmp("sub_result", result, 32'd0);
        cmp("sub_zero", zero, 32'h1);

        issue(2'b10, 4'b0011, 32'h0, 32'h1, 5'd4);
        tick(1);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            cmp("sll_busy", busy, 32'h1);
            tick(1);
        end
        cmp("sll_done", done, 32'h1);
        cmp("sll_result", result, 32'h10);

        issue(2'b10, 4'b0111, 32'h0, 32'h8000_0000, 5'd31);
        tick(31);
        start = 1'b0;
        cmp("srl_early", done, 32'h0);
        tick(1);
        cmp("srl_done", done, 32'h1);
        cmp("srl_result", result, 32'h1);

        issue(2'b10, 4'b0011, 32'h0, 32'h0000_ABCD, 5'd0);
        tick(1);
        start = 1'b0;
        cmp("sll0_done", done, 32'h1);
        cmp("sll0_result", result, 32'h0000_ABCD);

        issue(2'b10, 4'b1000, 32'd3, 32'hFFFF_FFFF, 5'd0);
        tick(1);
        start = 1'b0;
        tick(9);
        issue(2'b00, 4'b0000, 32'd1, 32'd1, 5'd0);
        tick(1);
        start = 1'b0;
        tick(21);
        cmp("mul_early", done, 32'h0);
        tick(1);
        cmp("mul_done", done, 32'h1);
        cmp("mul_result", result, 32'hFFFF_FFFD);
        tick(1);
        cmp("mul_single", done, 32'h0);

        issue(2'b10, 4'b1000, 32'd7, 32'd9, 5'd0);
        tick(1);
        start = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        cmp("abort_busy", busy, 32'h0);
        cmp("abort_result", result, 32'h0);
        cmp("abort_zero", zero, 32'h1);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) dcount++;
            tick(1);
        end
        cmp("abort_no_done", 32'(dcount), 32'h0);
        issue(2'b00, 4'b0000, 32'd2, 32'd2, 5'd0);
        tick(1);
        start = 1'b0;
        cmp("post_rst_add", result, 32'd4);

        issue(2'b10, 4'b1111, 32'd3, 32'd4, 5'd0);
        tick(1);
        cmp("ill_done", done, 32'h1);
        cmp("ill_flag", illegal, 32'h1);
        cmp("ill_result", result, 32'h0);
        issue(2'b11, 4'b0000, 32'h0, 32'h0, 5'd0);
        tick(1);
        start = 1'b0;
        cmp("nor_result", result, 32'hFFFF_FFFF);
        cmp("nor_illegal", illegal, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 1) == 1);
            aluop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: funct = 4'b0000;
                1: funct = 4'b0010;
                2: funct = 4'b0100;
                3: funct = 4'b0101;
                4: funct = 4'b1010;
                5: funct = 4'b0011;
                6: funct = 4'b0111;
                7: funct = 4'b1000;
                default: funct = 4'($urandom_range(0, 15));
            endcase
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            tick(1);
        end
        reset = 1'b0;
        start = 1'b0;
        tick(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
